// File: rtl/cache_mem_responder.sv
// Memory-side responder serving cache line/word refills and writebacks from an internal RAM.
// Optional macro CACHE_RESP_GAP_EN inserts one idle cycle between consecutive read beats.
module cache_mem_responder #(
  parameter int ADDR_W     = 12,
  parameter int RD_LAT     = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         err
);

  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;
  localparam logic [3:0] WAIT_CYC  = 4'(RD_LAT - 1);
  localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS - 1);
`ifdef CACHE_RESP_GAP_EN
  localparam logic GAP_EN = 1'b1;
`else
  localparam logic GAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST} state_t;

  state_t              state_q, state_d;
  logic [3:0]          wait_q, wait_d;
  logic [1:0]          beat_q, beat_d;
  logic                gap_q, gap_d;
  logic                line_q, line_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic                live_q, live_d;

  logic                wr_line, wr_word;
  logic [ADDR_W-1:0]   rd_word;
  logic [31:0]         mem [2**ADDR_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[31:ADDR_W+2], rd_addr[1:0],
                              wr_addr[31:ADDR_W+2], wr_addr[1:0]};

  assign rd_word = line_q ? {addr_q[ADDR_W-1:2], beat_q} : addr_q;
  assign err     = err_q;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    line_d    = line_q;
    addr_d    = addr_q;
    err_d     = err_q;
    live_d    = 1'b1;
    rd_rdy    = 1'b0;
    wr_rdy    = 1'b0;
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ret_data  = '0;
    wr_line   = 1'b0;
    wr_word   = 1'b0;

    case (state_q)
      IDLE: begin
        // live_q holds both readies low for the first cycle after reset is released
        wr_rdy = live_q && !reset;
        rd_rdy = live_q && !reset && !wr_req;
        if (wr_req && wr_rdy) begin
          if (wr_type == TYPE_LINE)      wr_line = 1'b1;
          else if (wr_type == TYPE_WORD) wr_word = 1'b1;
          else                           err_d   = 1'b1;
        end else if (rd_req && rd_rdy) begin
          addr_d = rd_addr[ADDR_W+1:2];
          line_d = (rd_type == TYPE_LINE);
          beat_d = '0;
          gap_d  = 1'b0;
          if (rd_type != TYPE_LINE && rd_type != TYPE_WORD) err_d = 1'b1;
          if (WAIT_CYC == 4'd0) begin
            state_d = RD_BURST;
          end else begin
            wait_d  = WAIT_CYC;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (wait_q <= 4'd1) state_d = RD_BURST;
        else                wait_d  = wait_q - 4'd1;
      end
      RD_BURST: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (!reset) begin
          ret_valid = 1'b1;
          ret_data  = mem[rd_word];
          ret_last  = !line_q || (beat_q == LAST_BEAT);
          if (ret_last) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 2'd1;
            gap_d  = GAP_EN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      beat_q  <= '0;
      gap_q   <= 1'b0;
      line_q  <= 1'b0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      live_q  <= live_d;
    end
  end

  // RAM has no reset; line writes ignore strobes and the in-line offset
  always_ff @(posedge clk) begin
    if (wr_line) begin
      for (int i = 0; i < 4; i++)
        mem[{wr_addr[ADDR_W+1:4], 2'(i)}] <= wr_data[32*i +: 32];
    end else if (wr_word) begin
      for (int k = 0; k < 4; k++)
        if (wr_wstrb[k]) mem[wr_addr[ADDR_W+1:2]][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: directed steps plus randomized traffic
// checked against a word-array reference model. Honours CACHE_RESP_GAP_EN.
module tb_cache_mem_responder;

  localparam int ADDR_W = 12;
  localparam int RD_LAT = 2;
`ifdef CACHE_RESP_GAP_EN
  localparam int SPACING = 2;
`else
  localparam int SPACING = 1;
`endif
  localparam logic [2:0] T_WORD = 3'b010;
  localparam logic [2:0] T_LINE = 3'b100;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         err;

  int          errors = 0;
  int          checks = 0;
  logic        model_err;
  logic [31:0] model_mem [2**ADDR_W];
  logic [31:0] got;

  cache_mem_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkOutput(tag, 32'(observed), 32'(expected));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic applyStimulus(input logic wreq, input logic [2:0] wtype, input logic [31:0] waddr,
                               input logic [3:0] wstrb, input logic [127:0] wdata,
                               input logic rreq, input logic [2:0] rtype, input logic [31:0] raddr);
    wr_req   = wreq;
    wr_type  = wtype;
    wr_addr  = waddr;
    wr_wstrb = wstrb;
    wr_data  = wdata;
    rd_req   = rreq;
    rd_type  = rtype;
    rd_addr  = raddr;
  endtask

  function automatic logic [ADDR_W-1:0] widx(input logic [31:0] a);
    return a[ADDR_W+1:2];
  endfunction

  task automatic model_write(input logic [2:0] wtype, input logic [31:0] addr,
                             input logic [3:0] strb, input logic [127:0] data);
    logic [ADDR_W-1:0] wi;
    wi = widx(addr);
    if (wtype == T_LINE) begin
      for (int i = 0; i < 4; i++) begin
        wi[1:0] = 2'(i);
        model_mem[wi] = data[32*i +: 32];
      end
    end else if (wtype == T_WORD) begin
      for (int k = 0; k < 4; k++)
        if (strb[k]) model_mem[wi][8*k +: 8] = data[8*k +: 8];
    end else begin
      model_err = 1'b1;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] wtype,
                          input logic [3:0] strb, input logic [127:0] data);
    applyStimulus(1'b1, wtype, addr, strb, data, 1'b0, 3'b000, 32'h0);
    settle;
    checkBit("wr_rdy_idle", wr_rdy, 1'b1);
    tick;
    model_write(wtype, addr, strb, data);
    applyStimulus(1'b0, 3'b000, 32'h0, 4'h0, 128'h0, 1'b0, 3'b000, 32'h0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] rtype, output logic [31:0] last_data);
    int                nb;
    int                last_off;
    int                beat;
    int                budget;
    logic              exp_v;
    logic              exp_l;
    logic [31:0]       exp_d;
    logic [ADDR_W-1:0] wi;
    last_data = 32'h0;
    applyStimulus(1'b0, 3'b000, 32'h0, 4'h0, 128'h0, 1'b1, rtype, addr);
    settle;
    budget = 0;
    while (rd_rdy !== 1'b1 && budget < 8) begin
      tick;
      settle;
      budget++;
    end
    checkBit("rd_accept", rd_rdy, 1'b1);
    tick;
    if (rtype != T_LINE && rtype != T_WORD) model_err = 1'b1;
    applyStimulus(1'b0, 3'b000, 32'h0, 4'h0, 128'h0, 1'b0, 3'b000, $urandom());
    nb = (rtype == T_LINE) ? 4 : 1;
    last_off = RD_LAT + (nb - 1) * SPACING;
    for (int k = 1; k <= last_off + 1; k++) begin
      settle;
      beat  = (k - RD_LAT) / SPACING;
      exp_v = (k >= RD_LAT) && (k <= last_off) && (((k - RD_LAT) % SPACING) == 0);
      exp_l = exp_v && (beat == nb - 1);
      wi    = widx(addr);
      if (nb == 4) wi[1:0] = 2'(beat);
      exp_d = exp_v ? model_mem[wi] : 32'h0;
      checkBit("ret_valid", ret_valid, exp_v);
      checkBit("ret_last", ret_last, exp_l);
      checkOutput("ret_data", ret_data, exp_d);
      checkBit("err_sticky", err, model_err);
      if (k <= last_off) begin
        checkBit("rd_rdy_busy", rd_rdy, 1'b0);
        checkBit("wr_rdy_busy", wr_rdy, 1'b0);
      end else begin
        checkBit("rd_rdy_after", rd_rdy, 1'b1);
        checkBit("wr_rdy_after", wr_rdy, 1'b1);
      end
      if (exp_l) last_data = ret_data;
      tick;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  r;
    for (int i = 0; i < 2**ADDR_W; i++) model_mem[i] = 32'h0;
    model_err = 1'b0;
    applyStimulus(1'b0, 3'b000, 32'h0, 4'h0, 128'h0, 1'b0, 3'b000, 32'h0);

    // Reset values
    reset = 1'b1;
    tick;
    tick;
    settle;
    checkBit("rst_rd_rdy", rd_rdy, 1'b0);
    checkBit("rst_wr_rdy", wr_rdy, 1'b0);
    checkBit("rst_ret_valid", ret_valid, 1'b0);
    checkBit("rst_ret_last", ret_last, 1'b0);
    checkOutput("rst_ret_data", ret_data, 32'h0);
    checkBit("rst_err", err, 1'b0);
    reset = 1'b0;
    tick;
    settle;
    checkBit("post_rst_rd_rdy", rd_rdy, 1'b1);
    checkBit("post_rst_wr_rdy", wr_rdy, 1'b1);
    tick;

    // Preload words 0..255 with back-to-back line writes
    for (int i = 0; i < 64; i++)
      do_write(32'(i * 16), T_LINE, 4'h0, {$urandom(), $urandom(), $urandom(), $urandom()});

    // Line write then line read from a mid-line address
    do_write(32'h100, T_LINE, 4'h0, {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000});
    do_read(32'h104, T_LINE, got);
    checkOutput("line_last_beat", got, 32'h33333333);

    // Byte-strobed word write
    do_write(32'h208, T_WORD, 4'hF, {96'h0, 32'h12345678});
    do_write(32'h208, T_WORD, 4'b0101, {$urandom(), $urandom(), $urandom(), 32'hAABBCCDD});
    do_read(32'h208, T_WORD, got);
    checkOutput("word_strobe", got, 32'h12BB56DD);

    // Simultaneous write and read: write wins, read follows
    applyStimulus(1'b1, T_WORD, 32'h300, 4'hF, {96'h0, 32'hCAFEF00D}, 1'b1, T_WORD, 32'h300);
    settle;
    checkBit("collide_rd_rdy", rd_rdy, 1'b0);
    checkBit("collide_wr_rdy", wr_rdy, 1'b1);
    tick;
    model_write(T_WORD, 32'h300, 4'hF, {96'h0, 32'hCAFEF00D});
    do_read(32'h300, T_WORD, got);
    checkOutput("collide_read", got, 32'hCAFEF00D);

    // Reset during beat 1 of a line read
    applyStimulus(1'b0, 3'b000, 32'h0, 4'h0, 128'h0, 1'b1, T_LINE, 32'h100);
    settle;
    checkBit("abort_accept", rd_rdy, 1'b1);
    tick;
    applyStimulus(1'b0, 3'b000, 32'h0, 4'h0, 128'h0, 1'b0, 3'b000, 32'h0);
    for (int k = 1; k <= RD_LAT; k++) begin
      settle;
      checkBit("abort_pre_valid", ret_valid, k == RD_LAT);
      tick;
    end
    reset = 1'b1;
    model_err = 1'b0;
    settle;
    checkBit("abort_rst_valid", ret_valid, 1'b0);
    checkBit("abort_rst_last", ret_last, 1'b0);
    tick;
    reset = 1'b0;
    settle;
    checkBit("abort_drop_valid", ret_valid, 1'b0);
    tick;
    settle;
    checkBit("abort_rd_rdy", rd_rdy, 1'b1);
    checkBit("abort_wr_rdy", wr_rdy, 1'b1);
    checkBit("abort_err", err, 1'b0);
    for (int k = 0; k < 6; k++) begin
      settle;
      checkBit("abort_quiet_valid", ret_valid, 1'b0);
      checkBit("abort_quiet_last", ret_last, 1'b0);
      tick;
    end

    // Unsupported types: err sticks, bad read served as one word
    do_write(32'h10, 3'b111, 4'hF, {$urandom(), $urandom(), $urandom(), $urandom()});
    settle;
    checkBit("bad_wr_err", err, 1'b1);
    tick;
    do_read(32'h10, 3'b001, got);
    do_read(32'h10, T_WORD, got);
    do_read(32'h40, T_LINE, got);

    // Randomized traffic with aliased upper address bits
    for (int n = 0; n < 60; n++) begin
      r = 4'($urandom_range(0, 4));
      a = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
      case (r)
        4'd0, 4'd1: do_write(a, T_LINE, 4'($urandom()), {$urandom(), $urandom(), $urandom(), $urandom()});
        4'd2:       do_write(a, T_WORD, 4'($urandom()), {$urandom(), $urandom(), $urandom(), $urandom()});
        4'd3:       do_read(a, T_LINE, got);
        default:    do_read(a, T_WORD, got);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
